// File: rtl/mem_image_loader.sv
// Memory image preloader: writes NUM_LINES consecutive lines from an image
// source over a valid/ready request channel, then optionally reads every line
// back and flags the first line whose data or tag does not match the image.
module mem_image_loader #(
    parameter int          DATA_WIDTH = 512,
    parameter int          ADDR_WIDTH = 26,
    parameter int          TAG_WIDTH  = 48,
    parameter int          NUM_LINES  = 16,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int          VERIFY     = 1,
    localparam int         IW         = $clog2(NUM_LINES) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [IW-1:0]         err_idx,
    output logic [IW-1:0]         img_idx,
    input  logic [DATA_WIDTH-1:0] img_data,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_rw,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_data,
    output logic [TAG_WIDTH-1:0]  req_tag,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    input  logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic                  rsp_ready
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WRITE   = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [IW-1:0]         LAST = IW'(NUM_LINES - 1);
    // Where the write phase goes after the last line.
    localparam logic [2:0]            S_AFTER_WR = (VERIFY != 0) ? S_RD_REQ : S_DONE;

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          error_q, error_d;
    logic [IW-1:0] err_idx_q, err_idx_d;

    logic hs, last, mism;

    // Outputs depend on state and index only, so req_valid never looks at req_ready
    // and the request stays stable until accepted.
    always_comb begin
        req_valid = (state_q == S_WRITE) || (state_q == S_RD_REQ);
        req_rw    = (state_q == S_WRITE);
        req_addr  = req_valid ? (BASE + ADDR_WIDTH'(idx_q)) : '0;
        req_tag   = req_valid ? TAG_WIDTH'(idx_q) : '0;
        req_data  = (state_q == S_WRITE) ? img_data : '0;
        rsp_ready = (state_q == S_RD_WAIT);
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);
        done      = (state_q == S_DONE);
        error     = error_q;
        err_idx   = err_idx_q;
        img_idx   = idx_q;
    end

    // Next-state logic: walk idx through the write phase, then the one-at-a-time read phase.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        hs        = req_valid && req_ready;
        last      = (idx_q == LAST);
        mism      = (rsp_data != img_data) || (rsp_tag != TAG_WIDTH'(idx_q));
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_WRITE;
                    idx_d     = '0;
                    error_d   = 1'b0;
                    err_idx_d = '0;
                end
            end
            S_WRITE: begin
                if (hs) begin
                    if (last) begin
                        state_d = S_AFTER_WR;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_RD_REQ: begin
                if (hs) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (rsp_valid) begin
                    // Keep only the first failing line.
                    if (mism && !error_q) begin
                        error_d   = 1'b1;
                        err_idx_d = idx_q;
                    end
                    if (last) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end else begin
                        state_d = S_RD_REQ;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset drops any outstanding request on the floor.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
        end
    end

endmodule

// File: tb/tb_mem_image_loader.sv
// Bench for mem_image_loader: a write-only instance (base 0x4) driven from a
// vector table, and a verifying instance (base near the top of the address
// space) attached to a one-deep memory model for read-back and reset cases.
module tb_mem_image_loader;

    localparam int DW = 512;
    localparam int AW = 26;
    localparam int TW = 48;
    localparam int NL = 4;
    localparam int IW = $clog2(NL) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [DW-1:0] img(input int i);
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = (32'hC0DE0000 + i) ^ (k << 20);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got low %h expected low %h", nm, act[63:0], exp[63:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance 0: VERIFY=0, BASE=0x4 ----------------
    logic          rst0 = 1'b0, start0 = 1'b0, ready0 = 1'b0;
    logic          busy0, done0, error0, req_valid0, req_rw0, rsp_ready0;
    logic [IW-1:0] err_idx0, img_idx0;
    logic [DW-1:0] img_data0, req_data0;
    logic [AW-1:0] req_addr0;
    logic [TW-1:0] req_tag0;
    int            hs0 = 0;

    assign img_data0 = img(int'(img_idx0));

    mem_image_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
                       .NUM_LINES(NL), .BASE_ADDR(32'h4), .VERIFY(0)) u0 (
        .clk(clk), .reset(rst0), .start(start0), .busy(busy0), .done(done0),
        .error(error0), .err_idx(err_idx0), .img_idx(img_idx0), .img_data(img_data0),
        .req_valid(req_valid0), .req_ready(ready0), .req_rw(req_rw0), .req_addr(req_addr0),
        .req_data(req_data0), .req_tag(req_tag0), .rsp_valid(1'b0), .rsp_data('0),
        .rsp_tag('0), .rsp_ready(rsp_ready0));

    always @(posedge clk) if (!rst0 && req_valid0 && ready0) hs0++;

    // ---------------- instance 1: VERIFY=1, BASE=0x3FFFFFE ----------------
    logic          rst1 = 1'b0, start1 = 1'b0, stray = 1'b0;
    logic          busy1, done1, error1, req_valid1, req_rw1, rsp_ready1, rsp_valid1;
    logic [IW-1:0] err_idx1, img_idx1;
    logic [DW-1:0] img_data1, req_data1, rsp_data1;
    logic [AW-1:0] req_addr1;
    logic [TW-1:0] req_tag1, rsp_tag1;
    logic [3:0]    corrupt = 4'b0000;

    logic [DW-1:0] mem1 [NL];
    logic          mrv = 1'b0;
    logic [DW-1:0] mrd = '0;
    logic [TW-1:0] mtag = '0;
    int            viol1 = 0;
    logic [AW-1:0] log_addr[$];
    logic          log_rw[$];
    logic [TW-1:0] log_tag[$];

    assign img_data1  = img(int'(img_idx1) + 100);
    assign rsp_valid1 = mrv | stray;
    assign rsp_data1  = mrd;
    assign rsp_tag1   = mtag;

    mem_image_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
                       .NUM_LINES(NL), .BASE_ADDR(32'h3FFFFFE), .VERIFY(1)) u1 (
        .clk(clk), .reset(rst1), .start(start1), .busy(busy1), .done(done1),
        .error(error1), .err_idx(err_idx1), .img_idx(img_idx1), .img_data(img_data1),
        .req_valid(req_valid1), .req_ready(1'b1), .req_rw(req_rw1), .req_addr(req_addr1),
        .req_data(req_data1), .req_tag(req_tag1), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
        .rsp_tag(rsp_tag1), .rsp_ready(rsp_ready1));

    // Memory model: stores writes by tag, answers a read on the next cycle,
    // optionally inverting the data of lines flagged in corrupt.
    always @(posedge clk) begin
        if (rst1) begin
            mrv <= 1'b0;
        end else begin
            if (mrv && rsp_ready1) mrv <= 1'b0;
            if (req_valid1) begin
                log_addr.push_back(req_addr1);
                log_rw.push_back(req_rw1);
                log_tag.push_back(req_tag1);
                if (req_rw1) begin
                    mem1[req_tag1[1:0]] <= req_data1;
                end else begin
                    if (mrv) viol1++;
                    mrv  <= 1'b1;
                    mrd  <= corrupt[req_tag1[1:0]] ? ~mem1[req_tag1[1:0]] : mem1[req_tag1[1:0]];
                    mtag <= req_tag1;
                end
            end
        end
    end

    task automatic wait_done1(input string nm);
        for (int i = 0; i < 200 && !done1; i++) step();
        chk(nm, done1, 1);
    endtask

    // ---------------- vector table for instance 0 ----------------
    typedef struct {
        logic          st;
        logic          rdy;
        logic          v;
        logic [AW-1:0] a;
        logic [TW-1:0] t;
        logic          dn;
        logic          bsy;
    } vec_t;

    function automatic vec_t mk(input logic s, r, v, input logic [AW-1:0] a, input int t,
                                input logic dn, bsy);
        vec_t x;
        x.st = s; x.rdy = r; x.v = v; x.a = a; x.t = TW'(t); x.dn = dn; x.bsy = bsy;
        return x;
    endfunction

    vec_t tv[$];
    logic [AW-1:0] ea[NL];
    int base;

    initial begin
        // run 1: ready high, one line per cycle, done 5 cycles after start
        tv.push_back(mk(0, 1, 1, 26'h4, 0, 0, 1));
        tv.push_back(mk(0, 1, 1, 26'h5, 1, 0, 1));
        tv.push_back(mk(0, 1, 1, 26'h6, 2, 0, 1));
        tv.push_back(mk(0, 1, 1, 26'h7, 3, 0, 1));
        tv.push_back(mk(1, 0, 0, 26'h0, 0, 1, 0));   // done; start reloads
        // run 2: ready 1 of every 3 cycles; start mid-run ignored
        tv.push_back(mk(0, 0, 1, 26'h4, 0, 0, 1));
        tv.push_back(mk(1, 0, 1, 26'h4, 0, 0, 1));
        tv.push_back(mk(0, 1, 1, 26'h4, 0, 0, 1));
        tv.push_back(mk(0, 0, 1, 26'h5, 1, 0, 1));
        tv.push_back(mk(0, 0, 1, 26'h5, 1, 0, 1));
        tv.push_back(mk(0, 1, 1, 26'h5, 1, 0, 1));
        tv.push_back(mk(0, 0, 1, 26'h6, 2, 0, 1));
        tv.push_back(mk(0, 0, 1, 26'h6, 2, 0, 1));
        tv.push_back(mk(0, 1, 1, 26'h6, 2, 0, 1));
        tv.push_back(mk(0, 0, 1, 26'h7, 3, 0, 1));
        tv.push_back(mk(0, 0, 1, 26'h7, 3, 0, 1));
        tv.push_back(mk(0, 1, 1, 26'h7, 3, 0, 1));
        tv.push_back(mk(0, 0, 0, 26'h0, 0, 1, 0));
        ea = '{26'h3FFFFFE, 26'h3FFFFFF, 26'h0, 26'h1};

        rst0 = 1'b1; rst1 = 1'b1;
        step(); step();
        rst0 = 1'b0; rst1 = 1'b0;

        // reset state
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_valid", req_valid0, 0);
        chk("rst_error", error0, 0);
        chk("rst_img_idx", img_idx0, 0);
        chk("rst_addr", req_addr0, 0);

        // instance 0 table
        start0 = 1'b1;
        step();
        for (int i = 0; i < tv.size(); i++) begin
            start0 = tv[i].st;
            ready0 = tv[i].rdy;
            chk($sformatf("v%0d_valid", i), req_valid0, tv[i].v);
            chk($sformatf("v%0d_addr", i), req_addr0, tv[i].a);
            chk($sformatf("v%0d_tag", i), req_tag0, tv[i].t);
            chk($sformatf("v%0d_done", i), done0, tv[i].dn);
            chk($sformatf("v%0d_busy", i), busy0, tv[i].bsy);
            if (tv[i].v) begin
                chk($sformatf("v%0d_rw", i), req_rw0, 1);
                chk($sformatf("v%0d_img_idx", i), img_idx0, tv[i].t);
                chkw($sformatf("v%0d_data", i), req_data0, img(int'(tv[i].t)));
            end
            step();
        end
        start0 = 1'b0;
        chk("u0_done_held", done0, 1);
        chk("u0_error", error0, 0);
        chk("u0_handshakes", hs0, 8);

        // instance 1: verify pass with echoing memory, wrapped addresses
        base = log_addr.size();
        start1 = 1'b1; step(); start1 = 1'b0;
        wait_done1("v1_done_reached");
        chk("v1_error", error1, 0);
        chk("v1_req_count", log_addr.size() - base, 2 * NL);
        for (int k = 0; k < 2 * NL && base + k < log_addr.size(); k++) begin
            chk($sformatf("v1_addr%0d", k), log_addr[base + k], ea[k % NL]);
            chk($sformatf("v1_rw%0d", k), log_rw[base + k], (k < NL) ? 1 : 0);
            chk($sformatf("v1_tag%0d", k), log_tag[base + k], k % NL);
        end
        chk("v1_one_outstanding", viol1, 0);

        // corrupt lines 2 and 3: first mismatch wins
        corrupt = 4'b1100;
        start1 = 1'b1; step(); start1 = 1'b0;
        chk("v2_done_dropped", done1, 0);
        wait_done1("v2_done_reached");
        chk("v2_error", error1, 1);
        chk("v2_err_idx", err_idx1, 2);
        corrupt = 4'b0000;

        // reset during RD_WAIT of line 1
        start1 = 1'b1; step(); start1 = 1'b0;
        for (int i = 0; i < 200 && !(rsp_ready1 && img_idx1 == 1); i++) step();
        chk("r_reached_rd_wait1", rsp_ready1 && img_idx1 == 1, 1);
        rst1 = 1'b1; step(); rst1 = 1'b0;
        chk("r_busy", busy1, 0);
        chk("r_done", done1, 0);
        chk("r_valid", req_valid1, 0);
        chk("r_rsp_ready", rsp_ready1, 0);
        chk("r_img_idx", img_idx1, 0);
        chk("r_addr", req_addr1, 0);
        chk("r_error", error1, 0);
        chk("r_err_idx", err_idx1, 0);

        // stray response while idle is ignored
        stray = 1'b1;
        chk("s_rsp_ready", rsp_ready1, 0);
        step();
        stray = 1'b0;
        chk("s_busy", busy1, 0);
        chk("s_error", error1, 0);

        // reload restarts from line 0
        base = log_addr.size();
        start1 = 1'b1; step(); start1 = 1'b0;
        chk("l_valid", req_valid1, 1);
        chk("l_addr", req_addr1, 26'h3FFFFFE);
        chk("l_tag", req_tag1, 0);
        wait_done1("l_done_reached");
        chk("l_error", error1, 0);
        chk("l_req_count", log_addr.size() - base, 2 * NL);
        chk("l_one_outstanding", viol1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
